param_demux_1x2: RTL and testbench

- Registered 1-to-2 stream demultiplexer. It is the inverse of the team's 2x1 parameterised mux.
- One valid/ready input stream of 2**N-bit words is steered to output y0 or y1 by a per-word selector.
- Each output has a one-entry holding register with its own valid/ready handshake, plus a wrapping count of the words delivered to it.
- It sits in the lab datapath wherever a shared source must feed one of two consumers without dropping or duplicating words.

---
 rtl/param_demux_pkg.sv | 15 +
 rtl/param_demux_chan_reg.sv | 61 ++++++
 rtl/param_demux_1x2.sv | 71 +++++++
 tb/tb_param_demux_1x2.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/param_demux_pkg.sv
// Shared types and helpers for the registered 1-to-2 stream demultiplexer.
package param_demux_pkg;

    // Selector encoding for the destination channel.
    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_t;

    // Data width derived from its log2.
    function automatic int data_width(input int n);
        return 2 ** n;
    endfunction

endpackage

// File: rtl/param_demux_chan_reg.sv
// One output channel: holding register, valid flag, ready-to-load term and
// wrapping delivered-word counter.
module demux_chan_reg
    import param_demux_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld,
    input  logic [W-1:0]     d,
    output logic [W-1:0]     data,
    output logic             valid,
    input  logic             ready,
    output logic             can_load,
    output logic [CNT_W-1:0] cnt
);

    logic [W-1:0]     data_q, data_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dr;

    assign dr       = valid_q & ready;
    assign can_load = ~valid_q | ready;

    // Next state: a drain clears valid and bumps the counter; a load in the
    // same cycle overrides the clear so back-to-back words keep valid high.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (dr) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (ld) begin
            data_d  = d;
            valid_d = 1'b1;
        end
    end

    // State register; reset discards any held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/param_demux_1x2.sv
// Registered 1-to-2 valid/ready demultiplexer. The top level only steers
// x_ready from the selected channel and decodes the per-channel load enable.
module param_demux_1x2
    import param_demux_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [data_width(N)-1:0]    x,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic                        sel,
    output logic [data_width(N)-1:0]    y0,
    output logic                        y0_valid,
    input  logic                        y0_ready,
    output logic [data_width(N)-1:0]    y1,
    output logic                        y1_valid,
    input  logic                        y1_ready,
    output logic [CNT_W-1:0]            cnt0,
    output logic [CNT_W-1:0]            cnt1
);

    localparam int W = data_width(N);

    chan_t sel_c;
    logic  can_load0, can_load1;
    logic  accept;
    logic  ld0, ld1;

    assign sel_c = chan_t'(sel);

    // x_ready looks only at the targeted channel so a stalled channel never
    // blocks words bound for the other one; it does not depend on x_valid.
    always_comb begin
        x_ready = can_load0;
        if (sel_c == CH1) begin
            x_ready = can_load1;
        end
    end

    assign accept = x_valid & x_ready;
    assign ld0    = accept & (sel_c == CH0);
    assign ld1    = accept & (sel_c == CH1);

    demux_chan_reg #(.W(W), .CNT_W(CNT_W)) u_chan0 (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld0),
        .d        (x),
        .data     (y0),
        .valid    (y0_valid),
        .ready    (y0_ready),
        .can_load (can_load0),
        .cnt      (cnt0)
    );

    demux_chan_reg #(.W(W), .CNT_W(CNT_W)) u_chan1 (
        .clk      (clk),
        .reset    (reset),
        .ld       (ld1),
        .d        (x),
        .data     (y1),
        .valid    (y1_valid),
        .ready    (y1_ready),
        .can_load (can_load1),
        .cnt      (cnt1)
    );

endmodule

// File: tb/tb_param_demux_1x2.sv
module tb_param_demux_1x2;

    logic       clk;
    logic       reset;
    logic [7:0] x;
    logic       x_valid;
    logic       x_ready;
    logic       sel;
    logic [7:0] y0;
    logic       y0_valid;
    logic       y0_ready;
    logic [7:0] y1;
    logic       y1_valid;
    logic       y1_ready;
    logic [3:0] cnt0;
    logic [3:0] cnt1;

    int n_assert;
    int n_fail;
    int n_accept;

    param_demux_1x2 #(.N(3), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .sel      (sel),
        .y0       (y0),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y1       (y1),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        n_accept = 0;
        reset    = 1'b1;
        x        = 8'h00;
        x_valid  = 1'b0;
        sel      = 1'b0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;

        // Reset release, idle
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_y0", y0, 0);
        chk("rst_y1", y1, 0);
        chk("rst_y0_valid", y0_valid, 0);
        chk("rst_y1_valid", y1_valid, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_xready_sel0", x_ready, 1);
        sel = 1'b1;
        #1;
        chk("rst_xready_sel1", x_ready, 1);

        // Single word to y0
        @(negedge clk);
        x = 8'hA5; sel = 1'b0; x_valid = 1'b1; y0_ready = 1'b1;
        #1;
        chk("single_xready", x_ready, 1);
        edge_sample();
        chk("single_y0", y0, 8'hA5);
        chk("single_y0_valid", y0_valid, 1);
        chk("single_y1_valid", y1_valid, 0);
        chk("single_cnt0_c1", cnt0, 0);
        @(negedge clk);
        x_valid = 1'b0;
        edge_sample();
        chk("single_cnt0_c2", cnt0, 1);
        chk("single_y0_valid_c2", y0_valid, 0);
        chk("single_y0_hold", y0, 8'hA5);

        // Stall on y0
        @(negedge clk);
        y0_ready = 1'b0; x = 8'h11; sel = 1'b0; x_valid = 1'b1;
        edge_sample();
        chk("stall_y0_11", y0, 8'h11);
        chk("stall_y0_valid", y0_valid, 1);
        @(negedge clk);
        x = 8'h22;
        #1;
        chk("stall_xready_low", x_ready, 0);
        edge_sample();
        chk("stall_y0_held", y0, 8'h11);
        @(negedge clk);
        y0_ready = 1'b1;
        #1;
        chk("stall_xready_drain", x_ready, 1);
        edge_sample();
        chk("stall_y0_22", y0, 8'h22);
        chk("stall_y0_valid_kept", y0_valid, 1);
        chk("stall_cnt0", cnt0, 2);

        // Stall isolation: y0 full and stalled, word to y1
        @(negedge clk);
        y0_ready = 1'b0; y1_ready = 1'b0; x = 8'h33; sel = 1'b1;
        #1;
        chk("iso_xready", x_ready, 1);
        edge_sample();
        chk("iso_y1", y1, 8'h33);
        chk("iso_y1_valid", y1_valid, 1);
        chk("iso_y0", y0, 8'h22);
        chk("iso_y0_valid", y0_valid, 1);
        chk("iso_cnt0", cnt0, 2);

        // Asynchronous reset while y0 holds a word
        @(negedge clk);
        x_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_y0_valid", y0_valid, 0);
        chk("async_cnt0", cnt0, 0);
        chk("async_y1_valid", y1_valid, 0);
        chk("async_y0", y0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Streaming 0x00..0x13, alternating sel, both readies high
        y0_ready = 1'b1; y1_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            x = 8'(i); sel = i[0]; x_valid = 1'b1;
            #1;
            if (x_ready) n_accept++;
            edge_sample();
            if (i[0] == 1'b0) begin
                chk("stream_y0", y0, i);
                chk("stream_y0_valid", y0_valid, 1);
                if (i > 0) chk("stream_y1_idle", y1_valid, 0);
            end else begin
                chk("stream_y1", y1, i);
                chk("stream_y1_valid", y1_valid, 1);
                chk("stream_y0_idle", y0_valid, 0);
            end
        end
        @(negedge clk);
        x_valid = 1'b0;
        edge_sample();
        chk("stream_accepts", n_accept, 20);
        chk("stream_cnt0", cnt0, 4'hA);
        chk("stream_cnt1", cnt1, 4'hA);

        // Counter wrap: 17 words to y1
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            x = 8'(8'h40 + i); sel = 1'b1; x_valid = 1'b1;
            edge_sample();
            chk("wrap_cnt1", cnt1, i % 16);
            chk("wrap_y1", y1, 8'h40 + i);
        end
        @(negedge clk);
        x_valid = 1'b0;
        edge_sample();
        chk("wrap_cnt1_final", cnt1, 1);
        chk("wrap_cnt0", cnt0, 0);
        chk("wrap_y1_valid", y1_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
